// File: rtl/reg_seq_pkg.sv
// rtl/reg_seq_pkg.sv - shared widths and FSM state encoding for the register-file sequencer
package reg_seq_pkg;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        OPER  = 3'd2,
        WB    = 3'd3,
        WRITE = 3'd4
    } state_e;

endpackage

// File: rtl/reg_seq_idx_decode.sv
// rtl/reg_seq_idx_decode.sv - register index to one-hot strobe decoder, all-zero when gated or out of range
module idx_decode #(
    parameter int IDX_W = 3,
    parameter int NREGS = 8
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [NREGS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (en_i && (idx_i == IDX_W'(i))) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_seq.sv
// rtl/reg_seq.sv - reg16 bank sequencer: read two sources, hand to ALU, write result back (ZERO_REG_EN hardwires r0)
module reg_seq #(
    parameter int NREGS  = 8,
    parameter int IDX_W  = reg_seq_pkg::IDX_W,
    parameter int DATA_W = reg_seq_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDX_W-1:0]  req_ra,
    input  logic [IDX_W-1:0]  req_rb,
    input  logic [IDX_W-1:0]  req_rd,
    input  logic              req_wr,
    input  logic [DATA_W-1:0] a_bus,
    input  logic [DATA_W-1:0] b_bus,
    output logic [NREGS-1:0]  sel_a,
    output logic [NREGS-1:0]  sel_b,
    output logic [NREGS-1:0]  en,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [DATA_W-1:0] wb_data,
    output logic              done
);

    import reg_seq_pkg::*;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ra_q, rb_q, rd_q;
    logic               wr_q;
    logic [DATA_W-1:0]  op_a_q, op_b_q, res_q;
    logic               done_q, done_d;
    logic               a_ok, b_ok, d_ok;

`ifdef ZERO_REG_EN
    assign a_ok = (ra_q != '0);
    assign b_ok = (rb_q != '0);
    assign d_ok = (rd_q != '0);
`else
    assign a_ok = 1'b1;
    assign b_ok = 1'b1;
    assign d_ok = 1'b1;
`endif

    idx_decode #(.IDX_W(IDX_W), .NREGS(NREGS)) u_dec_a (
        .idx_i    (ra_q),
        .en_i     ((state_q == READ) && a_ok),
        .onehot_o (sel_a)
    );

    idx_decode #(.IDX_W(IDX_W), .NREGS(NREGS)) u_dec_b (
        .idx_i    (rb_q),
        .en_i     ((state_q == READ) && b_ok),
        .onehot_o (sel_b)
    );

    idx_decode #(.IDX_W(IDX_W), .NREGS(NREGS)) u_dec_d (
        .idx_i    (rd_q),
        .en_i     ((state_q == WRITE) && wr_q && d_ok),
        .onehot_o (en)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (state_q == IDLE && req_valid) begin
                ra_q <= req_ra;
                rb_q <= req_rb;
                rd_q <= req_rd;
                wr_q <= req_wr;
            end
            // A dark strobe (out of range or hardwired zero) means the bus is not ours to sample.
            if (state_q == READ) begin
                op_a_q <= (|sel_a) ? a_bus : '0;
                op_b_q <= (|sel_b) ? b_bus : '0;
            end
            if (state_q == WB && wb_valid) begin
                res_q <= wb_data;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        req_ready = 1'b0;
        op_valid  = 1'b0;
        wb_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = READ;
            end
            READ: state_d = OPER;
            OPER: begin
                op_valid = 1'b1;
                if (op_ready) state_d = WB;
            end
            WB: begin
                wb_ready = 1'b1;
                if (wb_valid) begin
                    if (wr_q) begin
                        state_d = WRITE;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_oe  = |en;
    assign bus_out = bus_oe ? res_q : '0;
    assign op_a    = op_a_q;
    assign op_b    = op_b_q;
    assign done    = done_q;

endmodule

// File: tb/tb_reg_seq.sv
// tb/tb_reg_seq.sv - scoreboard bench for reg_seq with a modelled reg16 bank and handshaking ALU
module tb_reg_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wr, op_ready, wb_valid, bank_load;
    logic [2:0]  req_ra, req_rb, req_rd;
    logic [15:0] a_bus, b_bus, wb_data;

    logic        req_ready, bus_oe, op_valid, wb_ready, done;
    logic [7:0]  sel_a, sel_b, en;
    logic [15:0] bus_out, op_a, op_b;

    logic        req_ready6, bus_oe6, op_valid6, wb_ready6, done6;
    logic [5:0]  sel_a6, sel_b6, en6;
    logic [15:0] bus_out6, op_a6, op_b6;

    logic [15:0] bank [8];
    logic [15:0] ref_bank [8];

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int oe_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        logic [7:0]  sa, sb, en;
        logic [5:0]  en6;
        logic [15:0] a, b, d, a6;
    } exp_t;
    exp_t sb_q[$];

    logic [5:0]  obs_sa6, obs_en6;
    logic [15:0] obs_a6;
    logic        obs_done6;

    always #5 clk = ~clk;

    reg_seq #(.NREGS(8), .IDX_W(3), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_ra(req_ra), .req_rb(req_rb), .req_rd(req_rd), .req_wr(req_wr),
        .a_bus(a_bus), .b_bus(b_bus), .sel_a(sel_a), .sel_b(sel_b), .en(en),
        .bus_out(bus_out), .bus_oe(bus_oe), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .done(done)
    );

    reg_seq #(.NREGS(6), .IDX_W(3), .DATA_W(16)) dut6 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready6),
        .req_ra(req_ra), .req_rb(req_rb), .req_rd(req_rd), .req_wr(req_wr),
        .a_bus(a_bus), .b_bus(b_bus), .sel_a(sel_a6), .sel_b(sel_b6), .en(en6),
        .bus_out(bus_out6), .bus_oe(bus_oe6), .op_valid(op_valid6), .op_ready(op_ready),
        .op_a(op_a6), .op_b(op_b6), .wb_valid(wb_valid), .wb_ready(wb_ready6),
        .wb_data(wb_data), .done(done6)
    );

    always @(posedge clk) begin
        if (bank_load) begin
            for (int i = 0; i < 8; i++) bank[i] <= 16'(i) * 16'h1111;
            bank[0] <= 16'hA5A5;
            bank[2] <= 16'hF0F0;
            bank[5] <= 16'h0F0F;
            bank[7] <= 16'h1234;
        end else begin
            for (int i = 0; i < 8; i++) if (en[i] && bus_oe) bank[i] <= bus_out;
        end
    end

    always_comb begin
        a_bus = '0;
        b_bus = '0;
        for (int i = 0; i < 8; i++) begin
            if (sel_a[i]) a_bus = a_bus | bank[i];
            if (sel_b[i]) b_bus = b_bus | bank[i];
        end
    end

    always @(posedge clk) begin
        if (|en) en_cnt <= en_cnt + 1;
        if (bus_oe) oe_cnt <= oe_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic bit zr(input int i);
`ifdef ZERO_REG_EN
        return i == 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input int ra, input int rb, input int rd, input bit wr,
                           input int ops, input int wbs, output int lat);
        exp_t e, o;
        e.sa  = zr(ra) ? 8'h00 : 8'(1 << ra);
        e.sb  = zr(rb) ? 8'h00 : 8'(1 << rb);
        e.a   = zr(ra) ? 16'h0 : ref_bank[ra];
        e.b   = zr(rb) ? 16'h0 : ref_bank[rb];
        e.a6  = (ra < 6 && !zr(ra)) ? ref_bank[ra] : 16'h0;
        e.d   = e.a + e.b;
        e.en  = (wr && !zr(rd)) ? 8'(1 << rd) : 8'h00;
        e.en6 = (wr && rd < 6 && !zr(rd)) ? 6'(1 << rd) : 6'h00;
        sb_q.push_back(e);
        obs_en6 = '0;
        req_ra = 3'(ra); req_rb = 3'(rb); req_rd = 3'(rd); req_wr = wr; req_valid = 1'b1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_idle: got %b expected 1", req_ready); end
        step(); lat = 1; req_valid = 1'b0;
        o = sb_q.pop_front();
        checks++; if (sel_a !== o.sa) begin errors++; $display("FAIL sel_a: got %h expected %h", sel_a, o.sa); end
        checks++; if (sel_b !== o.sb) begin errors++; $display("FAIL sel_b: got %h expected %h", sel_b, o.sb); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL req_ready_read: got %b expected 0", req_ready); end
        obs_sa6 = sel_a6;
        step(); lat++;
        obs_a6 = op_a6;
        for (int i = 0; i <= ops; i++) begin
            checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL op_valid: got %b expected 1", op_valid); end
            checks++; if (op_a !== o.a || op_b !== o.b) begin errors++; $display("FAIL operands: got %h/%h expected %h/%h", op_a, op_b, o.a, o.b); end
            checks++; if (req_ready !== 1'b0 || en !== 8'h00) begin errors++; $display("FAIL busy_oper: got ready=%b en=%h expected 0/00", req_ready, en); end
            op_ready = (i == ops);
            step(); lat++;
        end
        op_ready = 1'b0;
        for (int i = 0; i <= wbs; i++) begin
            checks++; if (wb_ready !== 1'b1 || op_valid !== 1'b0) begin errors++; $display("FAIL wb_ready: got %b op_valid=%b expected 1/0", wb_ready, op_valid); end
            checks++; if (req_ready !== 1'b0 || en !== 8'h00) begin errors++; $display("FAIL busy_wb: got ready=%b en=%h expected 0/00", req_ready, en); end
            wb_valid = (i == wbs);
            wb_data = o.d;
            step(); lat++;
        end
        wb_valid = 1'b0;
        if (wr) begin
            checks++; if (en !== o.en || bus_oe !== (o.en != 0)) begin errors++; $display("FAIL en: got %h oe=%b expected %h oe=%b", en, bus_oe, o.en, (o.en != 0)); end
            if (o.en != 0) begin
                checks++; if (bus_out !== o.d) begin errors++; $display("FAIL bus_out: got %h expected %h", bus_out, o.d); end
            end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_early: got %b expected 0", done); end
            obs_en6 = en6;
            step(); lat++;
            if (o.en != 0) ref_bank[rd] = o.d;
        end
        checks++; if (done !== 1'b1 || req_ready !== 1'b1) begin errors++; $display("FAIL done: got done=%b ready=%b expected 1/1", done, req_ready); end
        checks++; if (en !== 8'h00 || bus_oe !== 1'b0) begin errors++; $display("FAIL en_after: got %h oe=%b expected 00/0", en, bus_oe); end
        checks++; if (bank[rd] !== ref_bank[rd]) begin errors++; $display("FAIL bank_r%0d: got %h expected %h", rd, bank[rd], ref_bank[rd]); end
        obs_done6 = done6;
    endtask

    task automatic test_reset();
        rst = 1'b0; bank_load = 1'b1; req_valid = 1'b0; req_wr = 1'b0;
        req_ra = '0; req_rb = '0; req_rd = '0; op_ready = 1'b0; wb_valid = 1'b0; wb_data = '0;
        repeat (2) step();
        bank_load = 1'b0;
        for (int i = 0; i < 8; i++) ref_bank[i] = 16'(i) * 16'h1111;
        ref_bank[0] = 16'hA5A5; ref_bank[2] = 16'hF0F0; ref_bank[5] = 16'h0F0F; ref_bank[7] = 16'h1234;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
        checks++; if ({sel_a, sel_b, en} !== 24'h0) begin errors++; $display("FAIL rst_strobes: got %h expected 0", {sel_a, sel_b, en}); end
        checks++; if ({bus_oe, op_valid, wb_ready, done} !== 4'b0) begin errors++; $display("FAIL rst_ctrl: got %b expected 0000", {bus_oe, op_valid, wb_ready, done}); end
        checks++; if ({bus_out, op_a, op_b} !== 48'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", {bus_out, op_a, op_b}); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int lat, e0;
        e0 = en_cnt;
        run_req(2, 5, 3, 1'b1, 0, 0, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL latency: got %0d expected 5", lat); end
        checks++; if (bank[3] !== 16'hFFFF) begin errors++; $display("FAIL basic_r3: got %h expected FFFF", bank[3]); end
        checks++; if (en_cnt - e0 !== 1) begin errors++; $display("FAIL basic_en_pulses: got %0d expected 1", en_cnt - e0); end
    endtask

    task automatic test_backpressure();
        int lat, e0;
        e0 = en_cnt;
        run_req(5, 2, 6, 1'b1, 3, 2, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL stall_latency: got %0d expected 10", lat); end
        checks++; if (en_cnt - e0 !== 1) begin errors++; $display("FAIL stall_en_pulses: got %0d expected 1", en_cnt - e0); end
    endtask

    task automatic test_no_wb();
        int lat, e0, o0;
        e0 = en_cnt; o0 = oe_cnt;
        run_req(1, 4, 6, 1'b0, 1, 1, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL nowb_latency: got %0d expected 6", lat); end
        checks++; if (en_cnt - e0 !== 0 || oe_cnt - o0 !== 0) begin errors++; $display("FAIL nowb_strobes: got en=%0d oe=%0d expected 0/0", en_cnt - e0, oe_cnt - o0); end
    endtask

    task automatic test_reset_mid();
        int lat, e0, d0;
        req_ra = 3'd3; req_rb = 3'd4; req_rd = 3'd1; req_wr = 1'b1; req_valid = 1'b1;
        step(); req_valid = 1'b0;
        step();
        checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL mid_in_oper: got %b expected 1", op_valid); end
        e0 = en_cnt; d0 = done_cnt;
        rst = 1'b0; op_ready = 1'b1;
        step();
        rst = 1'b1; op_ready = 1'b0;
        checks++; if (req_ready !== 1'b1 || op_valid !== 1'b0 || op_a !== 16'h0) begin errors++; $display("FAIL mid_reset: got ready=%b opv=%b op_a=%h expected 1/0/0000", req_ready, op_valid, op_a); end
        checks++; if ({sel_a, sel_b, en, bus_oe} !== 25'h0) begin errors++; $display("FAIL mid_strobes: got %h expected 0", {sel_a, sel_b, en, bus_oe}); end
        wb_valid = 1'b1; wb_data = 16'hDEAD;
        repeat (4) step();
        wb_valid = 1'b0;
        checks++; if (en_cnt - e0 !== 0 || done_cnt - d0 !== 0) begin errors++; $display("FAIL mid_aborted: got en=%0d done=%0d expected 0/0", en_cnt - e0, done_cnt - d0); end
        run_req(3, 4, 1, 1'b1, 0, 0, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL mid_recover_latency: got %0d expected 5", lat); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_req(3, 3, 4, 1'b1, 0, 0, lat);
        run_req(4, 3, 2, 1'b1, 1, 0, lat);
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_single_pulse: got %b expected 0", done); end
    endtask

    task automatic test_boundary();
        int lat;
        run_req(7, 7, 7, 1'b1, 0, 0, lat);
        checks++; if (obs_sa6 !== 6'h00 || obs_a6 !== 16'h0) begin errors++; $display("FAIL n6_read: got sel=%h op_a=%h expected 00/0000", obs_sa6, obs_a6); end
        checks++; if (obs_en6 !== 6'h00 || obs_done6 !== 1'b1) begin errors++; $display("FAIL n6_write: got en=%h done=%b expected 00/1", obs_en6, obs_done6); end
        checks++; if (bank[7] !== 16'h2468) begin errors++; $display("FAIL r7_sum: got %h expected 2468", bank[7]); end
    endtask

    task automatic test_zero_reg();
        int lat, e0;
        logic [15:0] exp_a;
        int exp_en;
`ifdef ZERO_REG_EN
        exp_a = 16'h0000; exp_en = 0;
`else
        exp_a = 16'hA5A5; exp_en = 1;
`endif
        e0 = en_cnt;
        req_ra = 3'd0; req_rb = 3'd0; req_rd = 3'd6; req_wr = 1'b0; req_valid = 1'b1;
        step(); req_valid = 1'b0;
        step();
        checks++; if (op_a !== exp_a) begin errors++; $display("FAIL r0_op_a: got %h expected %h", op_a, exp_a); end
        op_ready = 1'b1; step(); op_ready = 1'b0;
        wb_valid = 1'b1; wb_data = 16'h0; step(); wb_valid = 1'b0;
        run_req(0, 2, 0, 1'b1, 0, 0, lat);
        checks++; if (en_cnt - e0 !== exp_en || lat !== 5) begin errors++; $display("FAIL r0_write: got en=%0d lat=%0d expected %0d/5", en_cnt - e0, lat, exp_en); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_no_wb();
        test_reset_mid();
        test_back_to_back();
        test_boundary();
        test_zero_reg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
